// File: rtl/prefetch_pkg.sv
// Shared types and line geometry for the stream prefetcher.
// Holds the address/line widths used by the controller and its buffer,
// the FSM state encoding, the buffer entry layout and a tag helper.
package prefetch_pkg;

    localparam int ADDR_W     = 32;
    localparam int LINE_BYTES = 32;
    localparam int OFF        = $clog2(LINE_BYTES);
    localparam int TAG_W      = ADDR_W - OFF;
    localparam int LINE_W     = LINE_BYTES * 8;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [TAG_W-1:0]  tag_t;

    typedef struct packed {
        logic  valid;
        tag_t  tag;
        line_t data;
    } pf_entry_t;

    typedef logic [1:0] pf_state_t;
    localparam pf_state_t ST_IDLE     = 2'd0;
    localparam pf_state_t ST_DEMAND   = 2'd1;
    localparam pf_state_t ST_WRITE    = 2'd2;
    localparam pf_state_t ST_PREFETCH = 2'd3;

    // Line number of a byte address (drops the in-line offset).
    function automatic tag_t line_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFF];
    endfunction

endpackage

// File: rtl/pf_buffer.sv
// Fully associative prefetch line buffer with round-robin replacement.
// Ports:
//   clk, reset                  clock, async active-high reset (clears valids, rr pointer)
//   lookup_tag/hit/data         combinational lookup for the L2 request line
//   probe_tag/hit               combinational presence check for the next prefetch line
//   inv_en, inv_tag             drop any entry holding inv_tag
//   wr_en, wr_tag, wr_data      fill the entry at the round-robin pointer, then advance it
module pf_buffer
    import prefetch_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  tag_t  lookup_tag,
    output logic  lookup_hit,
    output line_t lookup_data,
    input  tag_t  probe_tag,
    output logic  probe_hit,
    input  logic  inv_en,
    input  tag_t  inv_tag,
    input  logic  wr_en,
    input  tag_t  wr_tag,
    input  line_t wr_data
);

    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    pf_entry_t          ents [ENTRIES];
    logic [PTR_W-1:0]   rr_ptr;

    // A line is only ever fetched when absent, so at most one entry matches.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        probe_hit   = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ents[i].valid && ents[i].tag == lookup_tag) begin
                lookup_hit  = 1'b1;
                lookup_data = ents[i].data;
            end
            if (ents[i].valid && ents[i].tag == probe_tag) begin
                probe_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ents[i] <= '0;
            end
            rr_ptr <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (inv_en && ents[i].valid && ents[i].tag == inv_tag) begin
                    ents[i].valid <= 1'b0;
                end
            end
            if (wr_en) begin
                ents[rr_ptr] <= '{valid: 1'b1, tag: wr_tag, data: wr_data};
                rr_ptr       <= (rr_ptr == PTR_W'(ENTRIES - 1)) ? '0 : rr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_prefetch_ctrl.sv
// Next-N-line stream prefetcher between the L2 cache and physical memory.
// Demand read misses go to pmem and start a stream of up to DEPTH sequential
// line prefetches into pf_buffer; later L2 reads that hit the buffer complete
// in the same cycle. Writes pass straight through and invalidate the buffered copy.
// Line geometry (ADDR_W, LINE_BYTES) comes from prefetch_pkg.
// Ports:
//   clk, reset            clock, async active-high reset
//   pf_en                 prefetch enable (0 = pass-through)
//   l2_read/l2_write      L2 request, held until l2_resp
//   l2_address/l2_wdata   request address (offset ignored) and write line
//   l2_rdata/l2_resp      read line and one-cycle completion
//   pmem_read/pmem_write  memory request, held until pmem_resp
//   pmem_address/wdata    line-aligned address, write line (= l2_wdata)
//   pmem_rdata/pmem_resp  memory read line and completion
//   dbg_state             current FSM state
// Handshake: a request is held high with stable address/data until its
// completion pulse; the pulse cycle is the last cycle the request is seen.
module stream_prefetch_ctrl
    import prefetch_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int ENTRIES   = 4,
    parameter int PAGE_BITS = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pf_en,
    input  logic              l2_read,
    input  logic              l2_write,
    input  logic [ADDR_W-1:0] l2_address,
    input  line_t             l2_wdata,
    output line_t             l2_rdata,
    output logic              l2_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output line_t             pmem_wdata,
    input  line_t             pmem_rdata,
    input  logic              pmem_resp,
    output pf_state_t         dbg_state
);

    localparam int          PG_W    = ADDR_W - PAGE_BITS;
    localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

    pf_state_t         state;
    logic [ADDR_W-1:0] pf_addr;
    logic [3:0]        pf_count;
    logic [PG_W-1:0]   page_tag;

    logic [ADDR_W-1:0] req_line, dem_next, pf_next;
    logic              dem_in_page, next_in_page, cur_in_page;
    logic              lookup_hit, probe_hit, inv_en, wr_en;
    line_t             lookup_data;
    logic              unused_addr_off;

    assign req_line     = {line_tag(l2_address), {OFF{1'b0}}};
    assign dem_next     = req_line + ADDR_W'(LINE_BYTES);
    assign pf_next      = pf_addr + ADDR_W'(LINE_BYTES);
    // Wrapping past 2^ADDR_W lands in a different page, so it also ends the stream.
    assign dem_in_page  = dem_next[ADDR_W-1:PAGE_BITS] == req_line[ADDR_W-1:PAGE_BITS];
    assign next_in_page = pf_next[ADDR_W-1:PAGE_BITS] == page_tag;
    assign cur_in_page  = pf_addr[ADDR_W-1:PAGE_BITS] == page_tag;
    assign pmem_wdata   = l2_wdata;
    assign dbg_state    = state;
    assign unused_addr_off = ^l2_address[OFF-1:0];

    pf_buffer #(.ENTRIES(ENTRIES)) u_buf (
        .clk         (clk),
        .reset       (reset),
        .lookup_tag  (line_tag(l2_address)),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .probe_tag   (line_tag(pf_addr)),
        .probe_hit   (probe_hit),
        .inv_en      (inv_en),
        .inv_tag     (line_tag(l2_address)),
        .wr_en       (wr_en),
        .wr_tag      (line_tag(pf_addr)),
        .wr_data     (pmem_rdata)
    );

    always_comb begin
        l2_resp      = 1'b0;
        l2_rdata     = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        inv_en       = 1'b0;
        wr_en        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (l2_write) begin
                    inv_en = 1'b1;
                end else if (l2_read && lookup_hit) begin
                    l2_resp  = 1'b1;
                    l2_rdata = lookup_data;
                end
            end
            ST_DEMAND: begin
                pmem_read    = 1'b1;
                pmem_address = req_line;
                if (pmem_resp) begin
                    l2_resp  = 1'b1;
                    l2_rdata = pmem_rdata;
                end
            end
            ST_WRITE: begin
                pmem_write   = 1'b1;
                pmem_address = req_line;
                l2_resp      = pmem_resp;
            end
            default: begin
                pmem_read    = 1'b1;
                pmem_address = pf_addr;
                wr_en        = pmem_resp;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            pf_addr  <= '0;
            pf_count <= '0;
            page_tag <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (l2_write) begin
                        state <= ST_WRITE;
                    end else if (l2_read) begin
                        if (!lookup_hit) begin
                            state <= ST_DEMAND;
                        end else if (!pf_en || !cur_in_page) begin
                            pf_count <= '0;
                        end else begin
                            // A hit shows the stream is in use: extend it by one, capped at DEPTH.
                            pf_count <= (pf_count >= DEPTH_C) ? DEPTH_C : pf_count + 4'd1;
                        end
                    end else if (!pf_en) begin
                        pf_count <= '0;
                    end else if (pf_count != '0) begin
                        if (probe_hit) begin
                            pf_addr  <= pf_next;
                            pf_count <= next_in_page ? pf_count - 4'd1 : '0;
                        end else begin
                            state <= ST_PREFETCH;
                        end
                    end
                end
                ST_DEMAND: begin
                    if (pmem_resp) begin
                        state    <= ST_IDLE;
                        pf_addr  <= dem_next;
                        page_tag <= req_line[ADDR_W-1:PAGE_BITS];
                        pf_count <= (pf_en && dem_in_page) ? DEPTH_C : '0;
                    end
                end
                ST_WRITE: begin
                    if (pmem_resp) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (pmem_resp) begin
                        state    <= ST_IDLE;
                        pf_addr  <= pf_next;
                        pf_count <= (pf_en && next_in_page) ? pf_count - 4'd1 : '0;
                    end
                end
            endcase
        end
    end

    a_no_read_write: assert property (@(posedge clk) disable iff (reset) !(l2_read && l2_write));

endmodule
